ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- Bus responder on the core's AHB-style request port: accepts single-beat read/write requests, serves them from an internal word-organised RAM, and replies with ahb_busy / ahb_rd_vld / ahb_rd_data.
- Inserts a programmable number of wait states.
- Flags decode, alignment and size errors on a sticky error output.
- Sits between the processor core and on-chip data memory.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h2000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W.
- WAIT_CYCLES, 1, extra busy cycles per access (0..15).

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ahb_en  input  1  request strobe; one cycle per request.
- ahb_wr_en  input  1  1 = write, 0 = read; sampled with ahb_en.
- ahb_addr  input  32  byte address; sampled with ahb_en.
- ahb_wr_data  input  32  write data, right-aligned; sampled with ahb_en.
- ahb_data_size  input  3  0 = byte, 1 = halfword, 2 = word; other values are errors.
- ahb_rd_data  output  32  read data, right-aligned and zero-extended.
- ahb_rd_vld  output  1  one-cycle pulse qualifying ahb_rd_data.
- ahb_busy  output  1  high while a request is in progress.
- err  output  1  sticky error flag.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async, rst_n low): state IDLE, wait counter 0, ahb_busy 0, ahb_rd_vld 0, ahb_rd_data 0, err 0. RAM contents are not reset.
- A reset mid-access abandons the access. A write is not committed unless its ACCESS edge has already occurred.
- Acceptance: ahb_en = 1 while ahb_busy = 0 (cycle T). The block latches wr_en, addr, wr_data and size.
- ahb_en while ahb_busy = 1 is a protocol violation. It is ignored and not queued.
- FSM IDLE -> WAIT -> ACCESS -> IDLE:
  - IDLE -> WAIT on acceptance; if WAIT_CYCLES = 0, IDLE -> ACCESS directly.
  - WAIT: counts WAIT_CYCLES cycles, then -> ACCESS.
  - ACCESS: one cycle. The RAM write happens at the closing edge, or the read data is registered. Then -> IDLE.
- Timing: ahb_busy = 1 from T+1 through T+1+WAIT_CYCLES and is 0 at T+2+WAIT_CYCLES.
- For reads, ahb_rd_vld = 1 and ahb_rd_data is valid only at T+2+WAIT_CYCLES. A new request may be accepted in that same cycle.
- ahb_rd_data holds its value until the next read completes.
- Writes produce no ahb_rd_vld.
- Decode: hit when ahb_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word index = addr[ADDR_W+1:2].
- Lanes are little-endian:
  - byte: lane addr[1:0], data wr_data[7:0].
  - halfword: lanes {addr[1],0}..+1, data wr_data[15:0].
  - word: all lanes.
- Reads extract the same lanes, shift them to bit 0 and zero-fill.
- Error cases: decode miss, halfword with addr[0] = 1, word with addr[1:0] != 0, or size > 2. On error:
  - The request still runs the full FSM with normal busy/vld timing, so the core never hangs.
  - Writes are dropped.
  - Reads return 32'h0 with ahb_rd_vld.
  - err is set at the ACCESS edge.
- err_clr: clears err at the next edge. If an error sets err in the same cycle, set wins.
- Back-to-back accesses to the same word: a read accepted at T+2+W after a write observes the new data.

Decomposition:
- Package ahb_bus_pkg:
  - size encodings SIZE_BYTE = 3'd0, SIZE_HALF = 3'd1, SIZE_WORD = 3'd2.
  - FSM state encodings S_IDLE, S_WAIT, S_ACCESS.
  - function for the 4-bit byte-lane mask from size and addr[1:0].
- Sub-module bus_lane_mux (combinational):
  - write side: byte-enable mask and lane-placed write word.
  - read side: right-aligned, zero-extended extraction.
- The top level holds the FSM, counter, request latch, RAM array and error logic.

Test Plan:
- Word write 32'hDEAD_BEEF to 0x2000_0010, then word read, WAIT_CYCLES = 1 -> busy high T+1..T+2; read returns 32'hDEAD_BEEF with rd_vld at T+3; err = 0.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x2000_0020..23, then word read -> 32'h4433_2211; halfword read at 0x2000_0022 -> 32'h0000_4433.
- Halfword read at 0x2000_0021 -> rd_vld with 32'h0 at normal latency; err = 1; err_clr pulse -> err = 0 next cycle.
- Write to 0x3000_0000 then read the same address -> write dropped; read returns 0; err = 1. A prior word at RAM index 0 is unchanged.
- ahb_en pulsed while busy -> ignored: no extra rd_vld and no RAM change. A request issued in the rd_vld cycle is accepted, so back-to-back reads are separated by 2 + WAIT_CYCLES cycles.
- rst_n asserted during WAIT of a write of 32'h1234_5678 -> busy and rd_vld go 0 immediately; after reset, a read of that address returns the old value.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared encodings and lane helper for the AHB-style SRAM responder.
package ahb_bus_pkg;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  // Little-endian byte-lane mask; an illegal size selects no lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      SIZE_HALF: lane_mask = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// Request/response signals between the core and the SRAM responder.
interface ahb_sram_slave_if;
  logic        ahb_en;
  logic        ahb_wr_en;
  logic [31:0] ahb_addr;
  logic [31:0] ahb_wr_data;
  logic [2:0]  ahb_data_size;
  logic [31:0] ahb_rd_data;
  logic        ahb_rd_vld;
  logic        ahb_busy;

  modport master (
    output ahb_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
    input  ahb_rd_data, ahb_rd_vld, ahb_busy
  );

  modport slave (
    input  ahb_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
    output ahb_rd_data, ahb_rd_vld, ahb_busy
  );
endinterface

// File: rtl/ahb_sram_slave_bus_lane_mux.sv
// Byte-lane steering: lane-placed write word with byte enables, and
// right-aligned zero-extended read extraction.
module bus_lane_mux
  import ahb_bus_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = rword_i >> {addr_lo_i, 3'b000};
  assign half_shift = rword_i >> {addr_lo_i[1], 4'b0000};

  // Replicating the right-aligned data means the enabled lanes always see it.
  always_comb begin
    be_o    = lane_mask(size_i, addr_lo_i);
    wword_o = wdata_i;
    rdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, byte_shift[7:0]};
      end
      SIZE_HALF: begin
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, half_shift[15:0]};
      end
      SIZE_WORD: rdata_o = rword_i;
      default:   rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// Single-beat AHB-style responder backed by a word RAM, with programmable
// wait states and a sticky error flag for decode/alignment/size faults.
module ahb_sram_slave
  import ahb_bus_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahb_sram_slave_if.slave      bus,
  output logic                 err,
  input  logic                 err_clr
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              accept;
  logic              access;
  logic              hit;
  logic              req_err;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       lane_rdata;

  assign accept   = (state_q == S_IDLE) && bus.ahb_en;
  assign access   = (state_q == S_ACCESS);
  assign word_idx = addr_q[ADDR_W+1:2];
  assign hit      = (addr_q[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign req_err  = !hit
                  || (size_q == SIZE_HALF && addr_q[0])
                  || (size_q == SIZE_WORD && addr_q[1:0] != 2'b00)
                  || (size_q > SIZE_WORD);

  bus_lane_mux u_lane_mux (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (mem[word_idx]),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ahb_en) begin
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_ACCESS;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Faulty reads still complete with zero data so the core never stalls.
  always_comb begin
    rd_vld_d  = access && !wr_q;
    rd_data_d = rd_data_q;
    if (access && !wr_q) rd_data_d = req_err ? 32'h0 : lane_rdata;
    err_d = err_q;
    if (err_clr)           err_d = 1'b0;
    if (access && req_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      size_q    <= 3'd0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      if (accept) begin
        wr_q    <= bus.ahb_wr_en;
        addr_q  <= bus.ahb_addr;
        wdata_q <= bus.ahb_wr_data;
        size_q  <= bus.ahb_data_size;
      end
    end
  end

  // RAM is not reset; state_q is forced to IDLE by reset, which gates writes.
  always_ff @(posedge clk) begin
    if (access && wr_q && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.ahb_busy    = (state_q != S_IDLE);
  assign bus.ahb_rd_vld  = rd_vld_q;
  assign bus.ahb_rd_data = rd_data_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: reads push expected data, a negedge monitor pops on rd_vld.
module tb_ahb_sram_slave;
  import ahb_bus_pkg::*;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  logic err_clr = 1'b0;

  ahb_sram_slave_if bus();

  ahb_sram_slave #(
    .ADDR_W      (10),
    .BASE_ADDR   (32'h2000_0000),
    .WAIT_CYCLES (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] expQ [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: every rd_vld pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.ahb_rd_vld === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected rd_vld: got data %h, expected no pulse", bus.ahb_rd_data);
      end else begin
        checkOutput("rd_data", bus.ahb_rd_data, expQ.pop_front());
      end
    end
  end

  // Issue one request at a negedge and check busy over its full lifetime.
  // Returns at the negedge of T+2+W, where a new request may be driven.
  task automatic applyStimulus(input string name, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] sz,
                               input logic [31:0] expRd, input bit poke);
    bus.ahb_en        = 1'b1;
    bus.ahb_wr_en     = wr;
    bus.ahb_addr      = a;
    bus.ahb_wr_data   = d;
    bus.ahb_data_size = sz;
    if (!wr) expQ.push_back(expRd);
    @(negedge clk);
    bus.ahb_en = 1'b0;
    for (int i = 0; i <= W; i++) begin
      checkOutput({name, " busy"}, {31'h0, bus.ahb_busy}, 32'h1);
      if (i == 0 && poke) begin
        bus.ahb_en        = 1'b1;
        bus.ahb_wr_en     = 1'b1;
        bus.ahb_addr      = 32'h2000_0010;
        bus.ahb_wr_data   = 32'hBAD0_BAD0;
        bus.ahb_data_size = SIZE_WORD;
      end
      @(negedge clk);
      bus.ahb_en = 1'b0;
    end
    checkOutput({name, " idle"}, {31'h0, bus.ahb_busy}, 32'h0);
  endtask

  task automatic clearErr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err after clear", {31'h0, err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ahb_en = 1'b0;
    bus.ahb_wr_en = 1'b0;
    bus.ahb_addr = 32'h0;
    bus.ahb_wr_data = 32'h0;
    bus.ahb_data_size = 3'd0;
    #12;
    checkOutput("reset busy",    {31'h0, bus.ahb_busy},   32'h0);
    checkOutput("reset rd_vld",  {31'h0, bus.ahb_rd_vld}, 32'h0);
    checkOutput("reset rd_data", bus.ahb_rd_data,         32'h0);
    checkOutput("reset err",     {31'h0, err},            32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write then read, and rd_data holds across a later write
    applyStimulus("w10", 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, SIZE_WORD, 32'h0, 1'b0);
    applyStimulus("r10", 1'b0, 32'h2000_0010, 32'h0, SIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    checkOutput("err after good read", {31'h0, err}, 32'h0);
    applyStimulus("w00", 1'b1, 32'h2000_0000, 32'h0BAD_F00D, SIZE_WORD, 32'h0, 1'b0);
    checkOutput("rd_data hold", bus.ahb_rd_data, 32'hDEAD_BEEF);

    // Byte lanes and sub-word reads
    applyStimulus("wb20", 1'b1, 32'h2000_0020, 32'hFFFF_FF11, SIZE_BYTE, 32'h0, 1'b0);
    applyStimulus("wb21", 1'b1, 32'h2000_0021, 32'h0000_0022, SIZE_BYTE, 32'h0, 1'b0);
    applyStimulus("wb22", 1'b1, 32'h2000_0022, 32'h0000_0033, SIZE_BYTE, 32'h0, 1'b0);
    applyStimulus("wb23", 1'b1, 32'h2000_0023, 32'h0000_0044, SIZE_BYTE, 32'h0, 1'b0);
    applyStimulus("r20",  1'b0, 32'h2000_0020, 32'h0, SIZE_WORD, 32'h4433_2211, 1'b0);
    applyStimulus("rh22", 1'b0, 32'h2000_0022, 32'h0, SIZE_HALF, 32'h0000_4433, 1'b0);
    applyStimulus("rh20", 1'b0, 32'h2000_0020, 32'h0, SIZE_HALF, 32'h0000_2211, 1'b0);
    applyStimulus("rb21", 1'b0, 32'h2000_0021, 32'h0, SIZE_BYTE, 32'h0000_0022, 1'b0);

    // Write then immediately read the same word; halfword write to upper lanes
    applyStimulus("w40",  1'b1, 32'h2000_0040, 32'hA5A5_5A5A, SIZE_WORD, 32'h0, 1'b0);
    applyStimulus("r40",  1'b0, 32'h2000_0040, 32'h0, SIZE_WORD, 32'hA5A5_5A5A, 1'b0);
    applyStimulus("wh42", 1'b1, 32'h2000_0042, 32'hFFFF_1234, SIZE_HALF, 32'h0, 1'b0);
    applyStimulus("r40b", 1'b0, 32'h2000_0040, 32'h0, SIZE_WORD, 32'h1234_5A5A, 1'b0);

    // Misaligned halfword read
    applyStimulus("rh21", 1'b0, 32'h2000_0021, 32'h0, SIZE_HALF, 32'h0, 1'b0);
    checkOutput("err misaligned half", {31'h0, err}, 32'h1);
    clearErr();

    // Decode miss: write dropped, read returns zero, index 0 untouched
    applyStimulus("wmiss", 1'b1, 32'h3000_0000, 32'h5555_5555, SIZE_WORD, 32'h0, 1'b0);
    checkOutput("err miss write", {31'h0, err}, 32'h1);
    clearErr();
    applyStimulus("rmiss", 1'b0, 32'h3000_0000, 32'h0, SIZE_WORD, 32'h0, 1'b0);
    checkOutput("err miss read", {31'h0, err}, 32'h1);
    clearErr();
    applyStimulus("r00", 1'b0, 32'h2000_0000, 32'h0, SIZE_WORD, 32'h0BAD_F00D, 1'b0);
    checkOutput("err good read", {31'h0, err}, 32'h0);

    // Illegal size and misaligned word, with err_clr held so set wins
    err_clr = 1'b1;
    applyStimulus("rsz3", 1'b0, 32'h2000_0020, 32'h0, 3'd3, 32'h0, 1'b0);
    err_clr = 1'b0;
    checkOutput("err set beats clear", {31'h0, err}, 32'h1);
    clearErr();
    applyStimulus("rw12", 1'b0, 32'h2000_0012, 32'h0, SIZE_WORD, 32'h0, 1'b0);
    checkOutput("err misaligned word", {31'h0, err}, 32'h1);
    clearErr();

    // Request while busy is ignored; reads issued in the rd_vld cycle are accepted
    applyStimulus("rpoke", 1'b0, 32'h2000_0020, 32'h0, SIZE_WORD, 32'h4433_2211, 1'b1);
    applyStimulus("r10b",  1'b0, 32'h2000_0010, 32'h0, SIZE_WORD, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT abandons the write
    applyStimulus("w30", 1'b1, 32'h2000_0030, 32'hCAFE_0001, SIZE_WORD, 32'h0, 1'b0);
    bus.ahb_en        = 1'b1;
    bus.ahb_wr_en     = 1'b1;
    bus.ahb_addr      = 32'h2000_0030;
    bus.ahb_wr_data   = 32'h1234_5678;
    bus.ahb_data_size = SIZE_WORD;
    @(negedge clk);
    bus.ahb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset busy",   {31'h0, bus.ahb_busy},   32'h0);
    checkOutput("mid-reset rd_vld", {31'h0, bus.ahb_rd_vld}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("r30", 1'b0, 32'h2000_0030, 32'h0, SIZE_WORD, 32'hCAFE_0001, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
